seg7_display: RTL and testbench
===============================

Name: seg7_display

Overview:
Memory-mapped output peripheral for the CPU bus. It is the write-side counterpart of the switch input port: the CPU stores a 32-bit value and a digit-enable mask. The block time-multiplexes the value as 8 hex digits onto the board's common-anode 7-segment display. It also returns both registers on the bus read path.

Parameters:
SCAN_DIV, 20000, clk cycles each digit stays lit; legal range >= 1 (benches use 4)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
we  input  1  bus write strobe, one cycle per write
addr  input  12  byte offset within the peripheral window; 0x000 = DATA, 0x004 = MASK
wdata  input  32  bus write data
rdata  output  32  registered read data for addr
dig_en  output  8  digit anode enables, active-low; bit i = digit i, digit 0 rightmost
seg  output  8  segment cathodes, active-low, order {dp,g,f,e,d,c,b,a}

Behaviour:
- Reset (rst high at a clk edge):
  - data_reg = 0, mask_reg = 8'hFF
  - scan counter cnt = 0, digit index idx = 0
  - dig_en = 8'hFF, seg = 8'hFF, rdata = 0
  - Reset mid-scan or mid-write aborts everything; any write in the same cycle is dropped.
- Writes, taking effect at the next edge:
  - we=1 and addr=0x000: data_reg <= wdata.
  - we=1 and addr=0x004: mask_reg <= wdata[7:0]; wdata[31:8] is ignored.
  - Any other addr: no effect.
  - Writes never disturb cnt or idx.
- Reads:
  - Every cycle, rdata <= (addr==0x000) ? data_reg : (addr==0x004) ? {24'd0, mask_reg} : 32'd0.
  - Latency is 1 cycle, with no strobe.
  - A read and write to the same addr in the same cycle returns the pre-write value; the new value appears one cycle later.
- Scan counter:
  - Each cycle, if cnt == SCAN_DIV-1 then cnt <= 0 and idx <= idx+1, with 3-bit wrap 7 -> 0. Otherwise cnt <= cnt+1.
  - With SCAN_DIV=1, idx advances every cycle.
  - cnt width is clog2(SCAN_DIV), minimum 1 bit.
- Display outputs are registered and computed each cycle from current idx, data_reg and mask_reg:
  - dig_en <= mask_reg[idx] ? ~(8'b1 << idx) : 8'hFF
  - seg <= decode(data_reg[4*idx+3 : 4*idx])
  - Outputs therefore lag idx by 1 cycle.
  - A DATA write is visible on seg 2 cycles after the we cycle, when the written digit is selected.
- Decode, hex digit -> seg:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=86, F=8E
  - dp is always off (bit7=1).
- Timing after reset release:
  - First edge with rst low: dig_en=8'hFE, seg=decode(data_reg[3:0]).
  - Each digit is then held for exactly SCAN_DIV cycles.
  - A full frame is 8*SCAN_DIV cycles.
- Invariant: at most one dig_en bit is low at any time. A masked digit gives dig_en=8'hFF for its slot, and the slot time is still consumed.

Test Plan:
1. Reset defaults: SCAN_DIV=4, hold rst 3 cycles, then release -> during reset dig_en=FF, seg=FF, rdata=0. First post-reset edge: dig_en=FE, seg=C0. Every digit shows C0; each slot lasts 4 cycles.
2. Scan sequence: write DATA=0x12345678, then observe 32 cycles -> (dig_en, seg) steps through:
   - (FE,80), (FD,F8), (FB,82), (F7,92)
   - (EF,99), (DF,B0), (BF,A4), (7F,F9)
   - Each pair held 4 cycles, then wraps to (FE,80).
3. Mask: with DATA=0x12345678, write MASK=0x0000_00A5 -> digits 1,3,4,6 show dig_en=FF for their slots. Digits 0,2,5,7 light normally; slot timing is unchanged.
4. Readback: write DATA=0xDEADBEEF with addr=0 held -> rdata=old value on the next cycle and 0xDEADBEEF one cycle later. Separately:
   - addr=0x004 -> rdata=0x000000A5
   - addr=0x008 -> rdata=0
5. Mid-scan write: during digit 2's slot, write DATA=0x00000F00 -> seg changes to 8E 2 cycles after we, within the same slot. cnt and idx are not disturbed, so the slot still ends on schedule.
6. Reset mid-operation: assert rst during digit 5 with we=1 and addr=0 -> write dropped. After release: data_reg=0, mask_reg=FF, scan restarts at digit 0 (dig_en=FE, seg=C0).

Source files
------------

// File: rtl/seg7_display.sv
// seg7_display: memory-mapped 8-digit hex display driver for the CPU bus.
// Holds a 32-bit DATA register and an 8-bit digit MASK register, scans the
// value across a common-anode 7-segment display one digit at a time, and
// returns both registers on a one-cycle-latency read path.
module seg7_display #(
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [11:0] ADDR_DATA = 12'h000;
  localparam logic [11:0] ADDR_MASK = 12'h004;

  logic [31:0]      data_q,   data_d;
  logic [7:0]       mask_q,   mask_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       idx_q,    idx_d;
  logic [31:0]      rdata_q,  rdata_d;
  logic [7:0]       dig_en_q, dig_en_d;
  logic [7:0]       seg_q,    seg_d;
  logic             slot_end;
  logic [3:0]       nibble;

  // Hex nibble to active-low {dp,g,f,e,d,c,b,a}; dp always off.
  function automatic logic [7:0] decode(input logic [3:0] hex);
    logic [7:0] s;
    case (hex)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Next-state logic: scan timing, register writes, read mux, display decode.
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rdata_d  = 32'd0;
    dig_en_d = 8'hFF;
    seg_d    = 8'hFF;
    nibble   = 4'h0;

    // Slot timer; writes never touch it.
    slot_end = (cnt_q == CNT_MAX);
    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (we) begin
      if (addr == ADDR_DATA) begin
        data_d = wdata;
      end else if (addr == ADDR_MASK) begin
        mask_d = wdata[7:0];
      end
    end

    // Read returns the pre-write register contents.
    if (addr == ADDR_DATA) begin
      rdata_d = data_q;
    end else if (addr == ADDR_MASK) begin
      rdata_d = {24'd0, mask_q};
    end

    // Display follows the current digit; a masked digit still uses its slot.
    nibble   = data_q[{idx_q, 2'b00} +: 4];
    seg_d    = decode(nibble);
    dig_en_d = mask_q[idx_q] ? ~(8'b1 << idx_q) : 8'hFF;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= 32'd0;
      mask_q   <= 8'hFF;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      rdata_q  <= 32'd0;
      dig_en_q <= 8'hFF;
      seg_q    <= 8'hFF;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      dig_en_q <= dig_en_d;
      seg_q    <= seg_d;
    end
  end

  assign rdata  = rdata_q;
  assign dig_en = dig_en_q;
  assign seg    = seg_q;

endmodule

// File: tb/tb_seg7_display.sv
// Directed self-checking bench for seg7_display with SCAN_DIV = 4.
module tb_seg7_display;

  localparam int unsigned SCAN_DIV = 4;

  logic        clk;
  logic        rst;
  logic        we;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  int n_pass;
  int n_total;
  int edges;  // clock edges since reset release

  seg7_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .dig_en (dig_en),
    .seg    (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle; tracks edges since reset release.
  task automatic step;
    @(posedge clk);
    if (rst) edges = 0;
    else     edges = edges + 1;
    #1;
  endtask

  // Step until the edge count within a frame equals target (at most 31 steps).
  task automatic align(input int target);
    for (int i = 0; i < 32; i++) begin
      if ((edges % 32) == target) break;
      step();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; we = 1'b0; addr = 12'h000; wdata = 32'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (dig_en !== 8'hFF || seg !== 8'hFF || rdata !== 32'd0)
        $display("FAIL reset_hold cyc%0d: dig_en=%h seg=%h rdata=%h want FF FF 0", i, dig_en, seg, rdata);
      else n_pass++;
    end
    rst = 1'b0;
    step();
    n_total++;
    if (dig_en !== 8'hFE || seg !== 8'hC0)
      $display("FAIL reset_first_edge: dig_en=%h seg=%h want FE C0", dig_en, seg);
    else n_pass++;
    // Rest of the first frame: all digits C0, 4 edges per slot.
    for (int n = 2; n <= 32; n++) begin
      logic [7:0] exp_dig;
      exp_dig = ~(8'b1 << ((n - 1) / 4));
      step();
      n_total++;
      if (dig_en !== exp_dig || seg !== 8'hC0)
        $display("FAIL reset_frame edge%0d: dig_en=%h seg=%h want %h C0", n, dig_en, seg, exp_dig);
      else n_pass++;
    end
  endtask

  task automatic test_scan;
    logic [7:0] dig_tab [8];
    logic [7:0] seg_tab [8];
    dig_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    seg_tab = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    align(31);
    we = 1'b1; addr = 12'h000; wdata = 32'h1234_5678;
    step();
    we = 1'b0;
    for (int k = 0; k < 33; k++) begin
      step();
      n_total++;
      if (dig_en !== dig_tab[(k / 4) % 8] || seg !== seg_tab[(k / 4) % 8])
        $display("FAIL scan k%0d: dig_en=%h seg=%h want %h %h", k, dig_en, seg,
                 dig_tab[(k / 4) % 8], seg_tab[(k / 4) % 8]);
      else n_pass++;
    end
  endtask

  task automatic test_mask;
    logic [7:0] dig_tab [8];
    logic [7:0] seg_tab [8];
    dig_tab = '{8'hFE, 8'hFF, 8'hFB, 8'hFF, 8'hFF, 8'hDF, 8'hFF, 8'h7F};
    seg_tab = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    align(31);
    we = 1'b1; addr = 12'h004; wdata = 32'h0000_00A5;
    step();
    we = 1'b0; addr = 12'h000;
    for (int k = 0; k < 32; k++) begin
      step();
      n_total++;
      if (dig_en !== dig_tab[k / 4] || seg !== seg_tab[k / 4])
        $display("FAIL mask k%0d: dig_en=%h seg=%h want %h %h", k, dig_en, seg,
                 dig_tab[k / 4], seg_tab[k / 4]);
      else n_pass++;
    end
  endtask

  task automatic test_readback;
    addr = 12'h000; we = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    we = 1'b0;
    n_total++;
    if (rdata !== 32'h1234_5678)
      $display("FAIL rd_pre_write: rdata=%h want 12345678", rdata);
    else n_pass++;
    step();
    n_total++;
    if (rdata !== 32'hDEAD_BEEF)
      $display("FAIL rd_post_write: rdata=%h want DEADBEEF", rdata);
    else n_pass++;
    addr = 12'h004;
    step();
    n_total++;
    if (rdata !== 32'h0000_00A5)
      $display("FAIL rd_mask: rdata=%h want 000000A5", rdata);
    else n_pass++;
    addr = 12'h008;
    step();
    n_total++;
    if (rdata !== 32'd0)
      $display("FAIL rd_unmapped: rdata=%h want 0", rdata);
    else n_pass++;
    // Write to an unmapped offset must not land anywhere.
    addr = 12'h008; we = 1'b1; wdata = 32'h0BAD_F00D;
    step();
    we = 1'b0; addr = 12'h000;
    step();
    n_total++;
    if (rdata !== 32'hDEAD_BEEF)
      $display("FAIL wr_unmapped_data: rdata=%h want DEADBEEF", rdata);
    else n_pass++;
    // Upper MASK write bits are dropped.
    addr = 12'h004; we = 1'b1; wdata = 32'hABCD_EFA5;
    step();
    we = 1'b0;
    step();
    n_total++;
    if (rdata !== 32'h0000_00A5)
      $display("FAIL wr_mask_upper: rdata=%h want 000000A5", rdata);
    else n_pass++;
    addr = 12'h000;
  endtask

  task automatic test_mid_scan;
    logic [7:0] dig_tab [5];
    logic [7:0] seg_tab [5];
    // DATA=DEADBEEF digit 2 is E (86); after writing 00000F00 it is F (8E).
    dig_tab = '{8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFF};
    seg_tab = '{8'h86, 8'h8E, 8'h8E, 8'h8E, 8'hC0};
    align(8);
    we = 1'b1; addr = 12'h000; wdata = 32'h0000_0F00;
    for (int k = 0; k < 5; k++) begin
      step();
      we = 1'b0;
      n_total++;
      if (dig_en !== dig_tab[k] || seg !== seg_tab[k])
        $display("FAIL mid_scan k%0d: dig_en=%h seg=%h want %h %h", k, dig_en, seg,
                 dig_tab[k], seg_tab[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    align(21);
    rst = 1'b1; we = 1'b1; addr = 12'h000; wdata = 32'h5555_5555;
    step();
    n_total++;
    if (dig_en !== 8'hFF || seg !== 8'hFF || rdata !== 32'd0)
      $display("FAIL rst_mid_hold: dig_en=%h seg=%h rdata=%h want FF FF 0", dig_en, seg, rdata);
    else n_pass++;
    rst = 1'b0; we = 1'b0;
    step();
    n_total++;
    if (dig_en !== 8'hFE || seg !== 8'hC0 || rdata !== 32'd0)
      $display("FAIL rst_mid_restart: dig_en=%h seg=%h rdata=%h want FE C0 0", dig_en, seg, rdata);
    else n_pass++;
    addr = 12'h004;
    step();
    n_total++;
    if (rdata !== 32'h0000_00FF || dig_en !== 8'hFE)
      $display("FAIL rst_mid_mask: rdata=%h dig_en=%h want 000000FF FE", rdata, dig_en);
    else n_pass++;
    addr = 12'h000;
    step();
    n_total++;
    if (rdata !== 32'd0 || seg !== 8'hC0)
      $display("FAIL rst_mid_drop: rdata=%h seg=%h want 0 C0", rdata, seg);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    edges   = 0;
    rst = 1'b1; we = 1'b0; addr = 12'h000; wdata = 32'd0;
    test_reset();
    test_scan();
    test_mask();
    test_readback();
    test_mid_scan();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
